// File: rtl/music_sequencer_multi.sv
// Multi-channel note sequencer: each channel walks its own {note_on, note, delay} ROM and holds each note for `delay` tempo ticks.
// Latency: the first note reaches note_out/gate_out 2 clk10Mhz cycles after start is sampled; a zero-delay event costs 2 cycles.
// Backpressure: none. The ROM answers one cycle after rom_addr. pause freezes tick counting, stop aborts every channel on the next edge.
//
// Ports:
//   clk10Mhz, reset        system clock, asynchronous active-high reset
//   tick, pause            one-cycle tempo strobe, level that freezes counting
//   start, stop, loop_en   playback control pulses; loop_en selects loop vs one-shot
//   msg_len, transpose     per-channel message count (0 = silent) and signed semitone shift
//   rom_addr, rom_data     per-channel ROM port; rom_data is valid one cycle after rom_addr
//   note_out, gate_out     registered, transposed note code and note-on per channel
//   busy, done             any channel active; one-cycle pulse when a one-shot run completes
module music_sequencer_multi #(
    parameter int CHANNELS    = 2,
    parameter int ADDR_BITS   = 10,
    parameter int NOTE_BITS   = 7,
    parameter int DELAY_BITS  = 12,
    parameter int NOTE_OFFSET = -12,
    parameter bit LOOP_SYNC   = 1'b1
) (
    input  logic                                       clk10Mhz,
    input  logic                                       reset,
    input  logic                                       tick,
    input  logic                                       start,
    input  logic                                       stop,
    input  logic                                       pause,
    input  logic                                       loop_en,
    input  logic [CHANNELS*(ADDR_BITS+1)-1:0]          msg_len,
    input  logic [CHANNELS*6-1:0]                      transpose,
    output logic [CHANNELS*ADDR_BITS-1:0]              rom_addr,
    input  logic [CHANNELS*(1+NOTE_BITS+DELAY_BITS)-1:0] rom_data,
    output logic [CHANNELS*NOTE_BITS-1:0]              note_out,
    output logic [CHANNELS-1:0]                        gate_out,
    output logic                                       busy,
    output logic                                       done
);

    localparam int WORD_BITS = 1 + NOTE_BITS + DELAY_BITS;
    localparam int SUM_BITS  = NOTE_BITS + 3;
    localparam logic signed [SUM_BITS-1:0] OFF_S = SUM_BITS'(NOTE_OFFSET);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_END} state_t;

    state_t                st_q   [CHANNELS];
    state_t                st_d   [CHANNELS];
    logic [ADDR_BITS-1:0]  addr_q [CHANNELS];
    logic [ADDR_BITS-1:0]  addr_d [CHANNELS];
    logic [DELAY_BITS-1:0] cnt_q  [CHANNELS];
    logic [DELAY_BITS-1:0] cnt_d  [CHANNELS];
    logic [NOTE_BITS-1:0]  note_q [CHANNELS];
    logic [NOTE_BITS-1:0]  note_d [CHANNELS];
    logic [CHANNELS-1:0]   gate_q;
    logic [CHANNELS-1:0]   gate_d;
    logic                  done_d;
    logic                  all_end;

    // Per-iteration scratch for the next-state loop.
    logic [ADDR_BITS:0]    len;
    logic [WORD_BITS-1:0]  word;
    logic [5:0]            tr;
    logic                  advance;

    // note + offset + transpose evaluated with 3 guard bits, then saturated.
    function automatic logic [NOTE_BITS-1:0] clamp_note(input logic [NOTE_BITS-1:0] n,
                                                        input logic [5:0]           t);
        logic signed [SUM_BITS-1:0] sum;
        sum = $signed({3'b000, n}) + $signed({{(SUM_BITS-6){t[5]}}, t}) + OFF_S;
        if (sum[SUM_BITS-1])
            clamp_note = '0;
        else if (|sum[SUM_BITS-2:NOTE_BITS])
            clamp_note = '1;
        else
            clamp_note = sum[NOTE_BITS-1:0];
    endfunction

    always_comb begin
        busy    = 1'b0;
        all_end = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (st_q[c] != S_IDLE) busy    = 1'b1;
            if (st_q[c] != S_END)  all_end = 1'b0;
        end
    end

    always_comb begin
        done_d  = 1'b0;
        gate_d  = gate_q;
        len     = '0;
        word    = '0;
        tr      = '0;
        advance = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            st_d[c]   = st_q[c];
            addr_d[c] = addr_q[c];
            cnt_d[c]  = cnt_q[c];
            note_d[c] = note_q[c];
            len       = msg_len[c*(ADDR_BITS+1) +: ADDR_BITS+1];
            word      = rom_data[c*WORD_BITS +: WORD_BITS];
            tr        = transpose[c*6 +: 6];
            advance   = 1'b0;

            if (stop) begin
                st_d[c]   = S_IDLE;
                addr_d[c] = '0;
                gate_d[c] = 1'b0;
            end else begin
                case (st_q[c])
                    S_IDLE: begin
                        // Every channel is idle together, so !busy also rejects start mid-run.
                        if (start && !busy) begin
                            addr_d[c] = '0;
                            st_d[c]   = (len == '0) ? S_END : S_FETCH;
                        end
                    end
                    S_FETCH: st_d[c] = S_LOAD;
                    S_LOAD: begin
                        note_d[c] = clamp_note(word[WORD_BITS-2 -: NOTE_BITS], tr);
                        gate_d[c] = word[WORD_BITS-1];
                        cnt_d[c]  = word[DELAY_BITS-1:0];
                        if (word[DELAY_BITS-1:0] == '0)
                            advance = 1'b1;
                        else
                            st_d[c] = S_WAIT;
                    end
                    S_WAIT: begin
                        if (tick && !pause) begin
                            cnt_d[c] = cnt_q[c] - DELAY_BITS'(1);
                            if (cnt_q[c] == DELAY_BITS'(1)) advance = 1'b1;
                        end
                    end
                    S_END: begin
                        gate_d[c] = 1'b0;
                        if (all_end) begin
                            if (loop_en && LOOP_SYNC) begin
                                addr_d[c] = '0;
                                st_d[c]   = (len == '0) ? S_END : S_FETCH;
                            end else if (!loop_en) begin
                                st_d[c] = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    default: st_d[c] = S_IDLE;
                endcase

                if (advance) begin
                    // addr+1 < len avoids underflow of len-1 if msg_len changes mid-run.
                    if (({1'b0, addr_q[c]} + (ADDR_BITS+1)'(1)) < len) begin
                        addr_d[c] = addr_q[c] + ADDR_BITS'(1);
                        st_d[c]   = S_FETCH;
                    end else if (loop_en && !LOOP_SYNC) begin
                        addr_d[c] = '0;
                        st_d[c]   = S_FETCH;
                    end else begin
                        st_d[c]   = S_END;
                        gate_d[c] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk10Mhz or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]   <= S_IDLE;
                addr_q[c] <= '0;
                cnt_q[c]  <= '0;
                note_q[c] <= '0;
            end
            gate_q <= '0;
            done   <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                st_q[c]   <= st_d[c];
                addr_q[c] <= addr_d[c];
                cnt_q[c]  <= cnt_d[c];
                note_q[c] <= note_d[c];
            end
            gate_q <= gate_d;
            done   <= done_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign rom_addr[g*ADDR_BITS +: ADDR_BITS] = addr_q[g];
        assign note_out[g*NOTE_BITS +: NOTE_BITS] = note_q[g];
    end
    assign gate_out = gate_q;

endmodule

// File: tb/tb_music_sequencer_multi.sv
// Bench for music_sequencer_multi: directed playback scenarios with a message-level reference model.
// Latency: checks sample outputs on the falling edge, half a cycle after each rising edge.
// Backpressure: none; tick is either a free-running strobe or pulsed by hand.
module tb_music_sequencer_multi;

    localparam int CH  = 2;
    localparam int AB  = 10;
    localparam int NB  = 7;
    localparam int DB  = 12;
    localparam int OFF = -12;
    localparam bit LS  = 1'b1;
    localparam int WB  = 1 + NB + DB;

    logic clk10Mhz = 1'b0;
    logic reset    = 1'b1;
    logic start    = 1'b0;
    logic stop     = 1'b0;
    logic pause    = 1'b0;
    logic loop_en  = 1'b0;
    logic auto_tick = 1'b0;
    logic man_tick  = 1'b0;
    logic tick;
    logic [CH*(AB+1)-1:0] msg_len   = '0;
    logic [CH*6-1:0]      transpose = '0;
    logic [CH*AB-1:0]     rom_addr;
    logic [CH*WB-1:0]     rom_data;
    logic [CH*NB-1:0]     note_out;
    logic [CH-1:0]        gate_out;
    logic                 busy;
    logic                 done;

    assign tick = auto_tick | man_tick;

    music_sequencer_multi #(
        .CHANNELS(CH), .ADDR_BITS(AB), .NOTE_BITS(NB), .DELAY_BITS(DB),
        .NOTE_OFFSET(OFF), .LOOP_SYNC(LS)
    ) dut (
        .clk10Mhz(clk10Mhz), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .pause(pause), .loop_en(loop_en), .msg_len(msg_len), .transpose(transpose),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_out(note_out),
        .gate_out(gate_out), .busy(busy), .done(done)
    );

    always #50 clk10Mhz = ~clk10Mhz;

    // Synchronous ROMs, one per channel.
    logic [WB-1:0] rom [CH][16];
    always @(posedge clk10Mhz)
        for (int c = 0; c < CH; c++)
            rom_data[c*WB +: WB] <= rom[c][rom_addr[c*AB +: 4]];

    int tick_period = 0;
    initial begin
        int tick_ctr;
        tick_ctr = 0;
        forever begin
            @(negedge clk10Mhz);
            tick_ctr++;
            if (tick_period != 0) auto_tick = ((tick_ctr % tick_period) == 0);
            else                  auto_tick = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_run, m_done;
    int m_idx [CH];
    int m_setup [CH];   // 2: address being presented, 1: word arriving, 0: holding
    int m_ticks [CH];
    bit m_park [CH];
    int m_note [CH];
    bit m_gate [CH];

    function automatic int mlen(input int c);
        return int'(msg_len[c*(AB+1) +: AB+1]);
    endfunction

    function automatic int mtr(input int c);
        int t;
        t = $signed(transpose[c*6 +: 6]);
        return t;
    endfunction

    function automatic int clampv(input int n, input int t);
        int v;
        v = n + OFF + t;
        if (v < 0) return 0;
        if (v > 127) return 127;
        return v;
    endfunction

    task automatic m_step(input int c);
        m_idx[c]++;
        if (m_idx[c] < mlen(c)) m_setup[c] = 2;
        else if (loop_en && !LS) begin m_idx[c] = 0; m_setup[c] = 2; end
        else begin m_park[c] = 1; m_setup[c] = 0; m_gate[c] = 0; end
    endtask

    always @(posedge clk10Mhz or posedge reset) begin
        bit all_park;
        logic [WB-1:0] w;
        if (reset) begin
            m_run = 0; m_done = 0;
            for (int c = 0; c < CH; c++) begin
                m_idx[c] = 0; m_setup[c] = 0; m_ticks[c] = 0;
                m_park[c] = 0; m_note[c] = 0; m_gate[c] = 0;
            end
        end else begin
            m_done = 0;
            all_park = m_run;
            for (int c = 0; c < CH; c++) if (!m_park[c]) all_park = 0;
            if (stop) begin
                m_run = 0;
                for (int c = 0; c < CH; c++) begin m_park[c] = 0; m_setup[c] = 0; m_gate[c] = 0; end
            end else if (!m_run) begin
                if (start) begin
                    m_run = 1;
                    for (int c = 0; c < CH; c++) begin
                        m_idx[c] = 0;
                        if (mlen(c) == 0) begin m_park[c] = 1; m_setup[c] = 0; end
                        else m_setup[c] = 2;
                    end
                end
            end else if (all_park) begin
                if (!loop_en) begin
                    m_run = 0; m_done = 1;
                    for (int c = 0; c < CH; c++) m_park[c] = 0;
                end else if (LS) begin
                    for (int c = 0; c < CH; c++)
                        if (mlen(c) != 0) begin m_park[c] = 0; m_idx[c] = 0; m_setup[c] = 2; end
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    if (m_park[c]) continue;
                    if (m_setup[c] == 2) m_setup[c] = 1;
                    else if (m_setup[c] == 1) begin
                        w = rom[c][m_idx[c]];
                        m_note[c]  = clampv(int'(w[WB-2 -: NB]), mtr(c));
                        m_gate[c]  = w[WB-1];
                        m_ticks[c] = int'(w[DB-1:0]);
                        m_setup[c] = 0;
                        if (m_ticks[c] == 0) m_step(c);
                    end else if (tick && !pause) begin
                        m_ticks[c]--;
                        if (m_ticks[c] == 0) m_step(c);
                    end
                end
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk10Mhz) begin
        if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
                check($sformatf("model_note%0d", c), 32'(note_out[c*NB +: NB]), m_note[c]);
                check($sformatf("model_gate%0d", c), 32'(gate_out[c]), 32'(m_gate[c]));
                if (m_run && !m_park[c] && m_setup[c] == 2)
                    check($sformatf("model_addr%0d", c), 32'(rom_addr[c*AB +: AB]), m_idx[c]);
            end
            check("model_busy", 32'(busy), 32'(m_run));
            check("model_done", 32'(done), 32'(m_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [WB-1:0] mk(input bit on, input int n, input int d);
        logic [WB-1:0] w;
        w = {on, n[NB-1:0], d[DB-1:0]};
        return w;
    endfunction

    task automatic set_len(input int c, input int v);
        msg_len[c*(AB+1) +: AB+1] = v[AB:0];
    endtask

    task automatic set_tr(input int c, input int v);
        transpose[c*6 +: 6] = v[5:0];
    endtask

    // Returns at the falling edge after the first note is loaded.
    task automatic start_and_settle();
        start = 1'b1;
        @(negedge clk10Mhz);
        start = 1'b0;
        @(negedge clk10Mhz);
        @(negedge clk10Mhz);
    endtask

    task automatic pulse_tick();
        man_tick = 1'b1;
        @(negedge clk10Mhz);
        man_tick = 1'b0;
    endtask

    task automatic run_to_idle(input string name, output int dones);
        dones = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk10Mhz);
            if (done) dones++;
            if (!busy) break;
        end
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        #(100 * 50000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        bit seen;
        for (int c = 0; c < CH; c++)
            for (int a = 0; a < 16; a++) rom[c][a] = '0;

        // Reset state
        repeat (3) @(negedge clk10Mhz);
        check("rst_note", 32'(note_out), 0);
        check("rst_gate", 32'(gate_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(rom_addr), 0);
        reset = 1'b0;
        chk_en = 1;
        @(negedge clk10Mhz);

        // 1: two-note one-shot, tick every 4 cycles
        rom[0][0] = mk(1, 60, 3);
        rom[0][1] = mk(1, 62, 2);
        set_len(0, 2); set_len(1, 0);
        loop_en = 1'b0; tick_period = 4;
        start_and_settle();
        check("t1_first_note", 32'(note_out[NB-1:0]), 48);
        check("t1_first_gate", 32'(gate_out[0]), 1);
        seen = 0; dones = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk10Mhz);
            if (note_out[NB-1:0] == 7'd50 && gate_out[0]) seen = 1;
            if (done) dones++;
            if (!busy) break;
        end
        check("t1_saw_50", 32'(seen), 1);
        check("t1_done_count", dones, 1);
        check("t1_busy_end", 32'(busy), 0);
        @(negedge clk10Mhz);
        check("t1_done_low", 32'(done), 0);

        // 2: zero-delay events step every 2 cycles
        rom[0][0] = mk(1, 60, 0);
        rom[0][1] = mk(1, 64, 0);
        rom[0][2] = mk(0, 0, 1);
        set_len(0, 3);
        start_and_settle();
        check("t2_note_a", 32'(note_out[NB-1:0]), 48);
        @(negedge clk10Mhz);
        check("t2_note_a_hold", 32'(note_out[NB-1:0]), 48);
        @(negedge clk10Mhz);
        check("t2_note_b", 32'(note_out[NB-1:0]), 52);
        check("t2_gate_b", 32'(gate_out[0]), 1);
        repeat (2) @(negedge clk10Mhz);
        check("t2_gate_c", 32'(gate_out[0]), 0);
        run_to_idle("t2", dones);
        check("t2_done_count", dones, 1);

        // 3: synchronised looping with unequal lengths, then stop+start together
        rom[0][0] = mk(1, 60, 2);
        rom[0][1] = mk(1, 62, 2);
        rom[1][0] = mk(1, 70, 1);
        set_len(0, 2); set_len(1, 1);
        loop_en = 1'b1;
        start_and_settle();
        check("t3_ch1_first", 32'(note_out[2*NB-1:NB]), 58);
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk10Mhz);
            if (!gate_out[1] && gate_out[0] && busy) seen = 1;
        end
        check("t3_ch1_silent_gap", 32'(seen), 1);
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk10Mhz);
            if (gate_out[1]) seen = 1;
        end
        check("t3_restart_seen", 32'(seen), 1);
        check("t3_restart_gate0", 32'(gate_out[0]), 1);
        check("t3_restart_note0", 32'(note_out[NB-1:0]), 48);
        check("t3_restart_note1", 32'(note_out[2*NB-1:NB]), 58);
        @(negedge clk10Mhz);
        stop = 1'b1; start = 1'b1;
        @(negedge clk10Mhz);
        stop = 1'b0; start = 1'b0;
        check("t3_stop_busy", 32'(busy), 0);
        check("t3_stop_gate", 32'(gate_out), 0);
        dones = 0;
        repeat (20) begin
            @(negedge clk10Mhz);
            if (done || busy) dones++;
        end
        check("t3_no_done_after_stop", dones, 0);

        // 4: clamp at both ends and a negative transpose in range
        loop_en = 1'b0;
        rom[0][0] = mk(1, 120, 1);
        rom[1][0] = mk(1, 60, 1);
        set_len(0, 1); set_len(1, 1);
        set_tr(0, 31); set_tr(1, -3);
        start_and_settle();
        check("t4_clamp_hi", 32'(note_out[NB-1:0]), 127);
        check("t4_tr_neg", 32'(note_out[2*NB-1:NB]), 45);
        run_to_idle("t4a", dones);
        rom[0][0] = mk(1, 5, 1);
        set_tr(0, -32); set_tr(1, 0);
        start_and_settle();
        check("t4_clamp_lo", 32'(note_out[NB-1:0]), 0);
        run_to_idle("t4b", dones);

        // 5: pause freezes counting with cnt=2
        tick_period = 0;
        @(negedge clk10Mhz);
        rom[0][0] = mk(1, 60, 3);
        rom[0][1] = mk(1, 62, 1);
        set_len(0, 2); set_len(1, 0); set_tr(0, 0);
        start_and_settle();
        pulse_tick();
        pause = 1'b1;
        repeat (10) begin pulse_tick(); @(negedge clk10Mhz); end
        check("t5_pause_note", 32'(note_out[NB-1:0]), 48);
        check("t5_pause_gate", 32'(gate_out[0]), 1);
        check("t5_pause_busy", 32'(busy), 1);
        pause = 1'b0;
        pulse_tick();
        repeat (4) @(negedge clk10Mhz);
        check("t5_one_more_tick", 32'(note_out[NB-1:0]), 48);
        pulse_tick();
        repeat (2) @(negedge clk10Mhz);
        check("t5_advanced", 32'(note_out[NB-1:0]), 50);
        pulse_tick();
        run_to_idle("t5", dones);
        check("t5_done_count", dones, 1);

        // 6: asynchronous reset between clock edges
        tick_period = 4;
        loop_en = 1'b1;
        rom[1][0] = mk(1, 70, 1);
        set_len(1, 1);
        start_and_settle();
        repeat (6) @(negedge clk10Mhz);
        check("t6_pre_busy", 32'(busy), 1);
        #10 reset = 1'b1;
        #1;
        check("t6_rst_note", 32'(note_out), 0);
        check("t6_rst_gate", 32'(gate_out), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_addr", 32'(rom_addr), 0);
        check("t6_rst_done", 32'(done), 0);
        @(negedge clk10Mhz);
        reset = 1'b0;
        repeat (3) @(negedge clk10Mhz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
